// File: rtl/wash_seq.sv
// ============================================================================
// Module   : wash_seq
// Brief    : Washer program sequencer driving the phase and sub-state LEDs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wash_seq #(
  parameter int UNIT_CMAX = 50000000,
  parameter int T_FIL     = 3,
  parameter int T_WAS     = 9,
  parameter int T_RIN     = 6,
  parameter int T_DRA     = 3,
  parameter int T_SPI     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sel,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  output logic [2:0] ld_drw,
  output logic [2:0] fl_drw,
  output logic [2:0] ld_fsd,
  output logic       busy,
  output logic       done,
  output logic [7:0] rem
);

  localparam int                 c_PRE_W = (UNIT_CMAX > 2) ? $clog2(UNIT_CMAX) : 1;
  localparam logic [c_PRE_W-1:0] c_TICK  = c_PRE_W'(UNIT_CMAX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WASH, S_RINSE, S_DRAIN, S_SPIN, S_PAUSE
  } state_t;

  state_t             state_q, state_d, ret_q, ret_d, eff_q, eff_d;
  logic [2:0]         prog_q, prog_d, phase_q, phase_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [c_PRE_W-1:0] pre_q, pre_d;
  logic               done_d, run;
  logic [2:0]         later, ld_drw_d, fl_drw_d, ld_fsd_d;

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    prog_d  = prog_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    run     = 1'b0;
    eff_q   = (state_q == S_PAUSE) ? ret_q : state_q;

    if (state_q == S_IDLE) begin
      if (start && (sel != 3'b000)) begin
        prog_d  = sel;
        phase_d = sel[0] ? 3'b001 : (sel[1] ? 3'b010 : 3'b100);
        pre_d   = '0;
        if (sel[1:0] != 2'b00) begin
          state_d = S_FILL;
          cnt_d   = 8'(T_FIL);
        end else begin
          state_d = S_SPIN;
          cnt_d   = 8'(T_SPI);
        end
      end
    end else if (abort) begin
      // phase=0 marks an aborted drain so its LEDs go dark and it ends without done
      prog_d  = 3'b000;
      phase_d = 3'b000;
      case (eff_q)
        S_FILL, S_WASH, S_RINSE: begin
          state_d = S_DRAIN;
          cnt_d   = 8'(T_DRA);
          pre_d   = '0;
        end
        S_DRAIN: begin
          state_d = S_DRAIN;
          run     = (state_q == S_DRAIN);
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
          pre_d   = '0;
        end
      endcase
    end else if (state_q == S_PAUSE) begin
      if (start) state_d = ret_q;
    end else if (pause) begin
      ret_d   = state_q;
      state_d = S_PAUSE;
    end else begin
      run = 1'b1;
    end

    if (run) begin
      if (pre_q != c_TICK) begin
        pre_d = pre_q + 1'b1;
      end else begin
        pre_d = '0;
        if (cnt_q != 8'd1) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          case (state_q)
            S_FILL: begin
              state_d = phase_d[1] ? S_RINSE : S_WASH;
              cnt_d   = phase_d[1] ? 8'(T_RIN) : 8'(T_WAS);
            end
            S_WASH, S_RINSE: begin
              state_d = S_DRAIN;
              cnt_d   = 8'(T_DRA);
            end
            S_DRAIN: begin
              if (phase_d[0] && prog_d[1]) begin
                state_d = S_FILL;
                phase_d = 3'b010;
                cnt_d   = 8'(T_FIL);
              end else if ((phase_d != 3'b000) && !phase_d[2] && prog_d[2]) begin
                state_d = S_SPIN;
                phase_d = 3'b100;
                cnt_d   = 8'(T_SPI);
              end else begin
                done_d  = (phase_d != 3'b000);
                state_d = S_IDLE;
                cnt_d   = 8'd0;
              end
            end
            default: begin
              done_d  = 1'b1;
              state_d = S_IDLE;
              cnt_d   = 8'd0;
            end
          endcase
          if (state_d == S_IDLE) begin
            prog_d  = 3'b000;
            phase_d = 3'b000;
          end
        end
      end
    end

    eff_d    = (state_d == S_PAUSE) ? ret_d : state_d;
    later    = phase_d[0] ? 3'b110 : (phase_d[1] ? 3'b100 : 3'b000);
    ld_drw_d = (state_d == S_IDLE) ? sel : (phase_d | (prog_d & later));
    fl_drw_d = ((state_d == S_IDLE) || (state_d == S_PAUSE)) ? 3'b000 : phase_d;
    case (eff_d)
      S_FILL:  ld_fsd_d = 3'b100;
      S_SPIN:  ld_fsd_d = 3'b010;
      S_DRAIN: ld_fsd_d = 3'b001;
      default: ld_fsd_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      prog_q  <= 3'b000;
      phase_q <= 3'b000;
      cnt_q   <= 8'd0;
      pre_q   <= '0;
      ld_drw  <= 3'b000;
      fl_drw  <= 3'b000;
      ld_fsd  <= 3'b000;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      prog_q  <= prog_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      ld_drw  <= ld_drw_d;
      fl_drw  <= fl_drw_d;
      ld_fsd  <= ld_fsd_d;
      busy    <= (state_d != S_IDLE);
      done    <= done_d;
    end
  end

  assign rem = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_wash_seq.sv
// ============================================================================
// Module   : tb_wash_seq
// Brief    : Directed self-checking bench for wash_seq with a 4-cycle time unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wash_seq;

  logic       clk = 1'b0;
  logic       rst, start, pause, abort;
  logic [2:0] sel;
  logic [2:0] ld_drw, fl_drw, ld_fsd;
  logic       busy, done;
  logic [7:0] rem;
  int         n_cmp = 0;
  int         n_err = 0;

  wash_seq #(
    .UNIT_CMAX(4), .T_FIL(3), .T_WAS(9), .T_RIN(6), .T_DRA(3), .T_SPI(6)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .start(start), .pause(pause), .abort(abort),
    .ld_drw(ld_drw), .fl_drw(fl_drw), .ld_fsd(ld_fsd),
    .busy(busy), .done(done), .rem(rem)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_ld, input logic [2:0] e_fl,
                         input logic [2:0] e_fsd, input logic e_busy, input logic e_done,
                         input logic [7:0] e_rem);
    chk({tag, ".ld_drw"}, 8'(ld_drw), 8'(e_ld));
    chk({tag, ".fl_drw"}, 8'(fl_drw), 8'(e_fl));
    chk({tag, ".ld_fsd"}, 8'(ld_fsd), 8'(e_fsd));
    chk({tag, ".busy"},   8'(busy),   8'(e_busy));
    chk({tag, ".done"},   8'(done),   8'(e_done));
    chk({tag, ".rem"},    rem,        e_rem);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 3'b000; start = 1'b0; pause = 1'b0; abort = 1'b0;
    step(3);
    rst = 1'b0;
    chk_all("reset", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'd0);

    // start with sel=000 is ignored
    pulse_start();
    chk_all("sel0_start", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'd0);

    // wash-only program; idle preview first
    sel = 3'b001;
    step(1);
    chk("preview", 8'(ld_drw), 8'h01);
    pulse_start();
    chk_all("t1_fill0", 3'b001, 3'b001, 3'b100, 1'b1, 1'b0, 8'd3);
    step(4);
    chk("t1_fill_e4.rem", rem, 8'd2);
    pulse_start();                                  // ignored while running
    chk_all("t1_restart_ign", 3'b001, 3'b001, 3'b100, 1'b1, 1'b0, 8'd2);
    step(6);
    chk_all("t1_fill_e11", 3'b001, 3'b001, 3'b100, 1'b1, 1'b0, 8'd1);
    step(1);
    chk_all("t1_wash0", 3'b001, 3'b001, 3'b000, 1'b1, 1'b0, 8'd9);
    step(36);
    chk_all("t1_drain0", 3'b001, 3'b001, 3'b001, 1'b1, 1'b0, 8'd3);
    step(11);
    chk_all("t1_drain_last", 3'b001, 3'b001, 3'b001, 1'b1, 1'b0, 8'd1);
    step(1);
    chk_all("t1_done", 3'b001, 3'b000, 3'b000, 1'b0, 1'b1, 8'd0);
    step(1);
    chk("t1_done_pulse", 8'(done), 8'h00);

    // full program: wash, rinse, dry
    sel = 3'b111;
    pulse_start();
    chk_all("t2_wash_fill", 3'b111, 3'b001, 3'b100, 1'b1, 1'b0, 8'd3);
    step(60);
    chk_all("t2_rinse_fill", 3'b110, 3'b010, 3'b100, 1'b1, 1'b0, 8'd3);
    step(12);
    chk_all("t2_rinse", 3'b110, 3'b010, 3'b000, 1'b1, 1'b0, 8'd6);
    step(36);
    chk_all("t2_spin", 3'b100, 3'b100, 3'b010, 1'b1, 1'b0, 8'd6);
    step(23);
    chk_all("t2_spin_last", 3'b100, 3'b100, 3'b010, 1'b1, 1'b0, 8'd1);
    step(1);
    chk_all("t2_done", 3'b111, 3'b000, 3'b000, 1'b0, 1'b1, 8'd0);

    // pause 10 cycles into WASH, resume: completion shifts by 20 cycles
    sel = 3'b001;
    pulse_start();
    step(21);
    chk("t3_wash_e21.rem", rem, 8'd7);
    pause = 1'b1; step(1); pause = 1'b0;
    chk_all("t3_paused", 3'b001, 3'b000, 3'b000, 1'b1, 1'b0, 8'd7);
    step(18);
    chk_all("t3_paused_end", 3'b001, 3'b000, 3'b000, 1'b1, 1'b0, 8'd7);
    pulse_start();
    chk_all("t3_resumed", 3'b001, 3'b001, 3'b000, 1'b1, 1'b0, 8'd7);
    step(38);
    chk_all("t3_before_done", 3'b001, 3'b001, 3'b001, 1'b1, 1'b0, 8'd1);
    step(1);
    chk_all("t3_done", 3'b001, 3'b000, 3'b000, 1'b0, 1'b1, 8'd0);

    // abort 5 cycles into WASH -> dark drain, no done
    pulse_start();
    step(16);
    abort = 1'b1; step(1); abort = 1'b0;
    chk_all("t4_abort_drain", 3'b000, 3'b000, 3'b001, 1'b1, 1'b0, 8'd3);
    step(11);
    chk_all("t4_drain_last", 3'b000, 3'b000, 3'b001, 1'b1, 1'b0, 8'd1);
    step(1);
    chk_all("t4_idle", 3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 8'd0);
    step(1);
    chk("t4_no_done", 8'(done), 8'h00);

    // abort during SPIN -> IDLE next cycle
    sel = 3'b100;
    pulse_start();
    sel = 3'b000;
    chk_all("t4_spin", 3'b100, 3'b100, 3'b010, 1'b1, 1'b0, 8'd6);
    step(5);
    abort = 1'b1; step(1); abort = 1'b0;
    chk_all("t4_spin_abort", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'd0);

    // reset mid-RINSE, then a normal run
    sel = 3'b010;
    pulse_start();
    step(15);
    chk_all("t6_rinse", 3'b010, 3'b010, 3'b000, 1'b1, 1'b0, 8'd6);
    rst = 1'b1; step(1); rst = 1'b0;
    chk_all("t6_rst", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'd0);
    sel = 3'b001;
    pulse_start();
    chk_all("t6_restart", 3'b001, 3'b001, 3'b100, 1'b1, 1'b0, 8'd3);
    step(60);
    chk_all("t6_done", 3'b001, 3'b000, 3'b000, 1'b0, 1'b1, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
